mem_fifo_ctrl: RTL
==================

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL be the byte width of the memory word.
REQ-002 Parameter ADDR_W, default 6, SHALL be the memory address width; depth is 2**ADDR_W = 64.
REQ-003 Ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Ports: reset  input  1  synchronous, active-high reset.
REQ-005 Ports: wr_valid_i  input  1  producer offers a byte.
REQ-006 Ports: wr_data_i  input  DATA_W  offered byte.
REQ-007 Ports: wr_ready_o  output  1  write accepted this cycle when high with wr_valid_i.
REQ-008 Ports: rd_req_i  input  1  consumer requests the oldest byte.
REQ-009 Ports: rd_ready_o  output  1  read accepted this cycle when high with rd_req_i.
REQ-010 Ports: rd_valid_o  output  1  rd_data_o holds a returned byte.
REQ-011 Ports: rd_data_o  output  DATA_W  returned byte.
REQ-012 Ports: sel_o  output  1  to memory interface sel; 0 = write cycle (we=1), 1 = read/idle (we=0).
REQ-013 Ports: addr_0_o  output  ADDR_W  write address (write pointer).
REQ-014 Ports: addr_1_o  output  ADDR_W  read address (read pointer).
REQ-015 Ports: data_o  output  DATA_W  write data to memory interface data_i.
REQ-016 Ports: q_i  input  DATA_W  read data from memory interface q_o; valid one cycle after read cycle.
REQ-017 Ports: count_o  output  ADDR_W+1  occupancy 0..64; full_o, empty_o  output  1 each.

Function
REQ-018 Block SHALL operate the downstream single-port 64x8 memory as a FIFO; one memory access per cycle.
REQ-019 rd_ready_o SHALL be !empty_o; wr_ready_o SHALL be !full_o && !(rd_req_i && !empty_o) (read has priority).
REQ-020 Read cycle (rd_req_i && rd_ready_o): sel_o=1, addr_1_o=rd_ptr; rd_ptr increments at the edge.
REQ-021 Write cycle (wr_valid_i && wr_ready_o): sel_o=0, addr_0_o=wr_ptr, data_o=wr_data_i; wr_ptr increments at the edge.
REQ-022 Idle cycle (neither handshake): sel_o SHALL be 1 so no memory write occurs; data_o=wr_data_i.
REQ-023 addr_0_o SHALL always equal wr_ptr and addr_1_o SHALL always equal rd_ptr (both registered pointers).
REQ-024 Pointers SHALL wrap 63 -> 0 modulo 2**ADDR_W.
REQ-025 count_o SHALL +1 per accepted write, -1 per accepted read; never both in one cycle.
REQ-026 full_o SHALL be (count_o==64); empty_o SHALL be (count_o==0).
REQ-027 rd_valid_o SHALL be a registered copy of the read handshake, high exactly one cycle after it; rd_data_o=q_i in that cycle.
REQ-028 rd_data_o SHALL be 0 whenever rd_valid_o is 0.
REQ-029 Write when full and read when empty SHALL be refused with no state change.
REQ-030 Both requests while empty: write SHALL proceed, read refused.

Reset
REQ-031 reset high at a rising edge SHALL clear wr_ptr, rd_ptr, count_o, rd_valid_o; outputs then: sel_o=1, addr_0_o=0, addr_1_o=0, empty_o=1, full_o=0, rd_data_o=0.
REQ-032 reset SHALL override any handshake in the same cycle; a read issued the cycle before reset SHALL NOT raise rd_valid_o after it.
REQ-033 While reset is high sel_o SHALL be 1 (no memory write).

Structure
REQ-034 DATA_W, ADDR_W and DEPTH constants SHALL live in a shared memory-constants package/header used by this block and the memory interface.
REQ-035 One sub-module ptr_counter (ADDR_W-bit wrapping counter with enable and synchronous reset) SHALL be instantiated twice for wr_ptr and rd_ptr.

Verification
REQ-036 Write 0x11,0x22,0x33 then read 3 -> sel_o=0 on writes at addr 0,1,2; rd_data_o 0x11,0x22,0x33 each one cycle after request; empty_o=1 at end.
REQ-037 64 writes -> full_o=1, count_o=64, wr_ready_o=0; 65th wr_valid_i yields no sel_o=0 cycle.
REQ-038 Read on empty -> rd_ready_o=0, sel_o=1, rd_valid_o stays 0, count_o=0.
REQ-039 count=5, rd_req_i and wr_valid_i together -> read wins, sel_o=1, wr_ready_o=0, count_o=4 next cycle.
REQ-040 Fill 64, read 64, write 0xA5 -> written at addr 0 (wrap), read back 0xA5.
REQ-041 Reset asserted in cycle after a read issue with count=10 -> rd_valid_o=0, count_o=0, pointers 0, sel_o=1.

Source files
------------

// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared memory constants for the FIFO controller and the 64x8 single-port memory interface.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_fifo_ctrl_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

endpackage

// File: rtl/mem_fifo_ctrl_ptr_counter.sv
// Wrapping W-bit pointer counter with enable and synchronous active-high reset.
// Latency: new value visible one cycle after en_i.
// Backpressure: none; caller gates en_i.
module ptr_counter
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int W = MEM_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Natural overflow gives the modulo 2**W wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller driving an external single-port memory, one access per cycle, read beats write.
// Latency: write stored at the accepting edge; read data returned one cycle after the read handshake.
// Backpressure: wr_ready_o drops when full or when a read takes the memory; rd_ready_o drops when empty.
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              rd_req_i,
    output logic              rd_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              sel_o,
    output logic [ADDR_W-1:0] addr_0_o,
    output logic [ADDR_W-1:0] addr_1_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] q_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic              rd_fire;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign rd_ready_o = !empty_o;
    assign wr_ready_o = !full_o && !(rd_req_i && !empty_o);

    assign rd_fire = rd_req_i && rd_ready_o;
    assign wr_fire = wr_valid_i && wr_ready_o;

    // The memory only writes when sel_o is low; reset must never let a write through.
    assign sel_o    = reset || !wr_fire;
    assign addr_0_o = wr_ptr;
    assign addr_1_o = rd_ptr;
    assign data_o   = wr_data_i;

    always_comb begin
        count_d    = count_q;
        rd_valid_d = rd_fire;
        if (wr_fire) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_fire) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ptr_counter #(.W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (wr_fire),
        .cnt_o (wr_ptr)
    );

    ptr_counter #(.W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (rd_fire),
        .cnt_o (rd_ptr)
    );

    assign count_o    = count_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? q_i : '0;

endmodule
